// File: rtl/exe_div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for the EXE stage.
// Owns the HI/LO registers: division results commit on ack; MTHI/MTLO write directly.
module exe_div_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              ack,
  input  logic              cancel,
  input  logic              hi_wen,
  input  logic              lo_wen,
  input  logic [DATA_W-1:0] hilo_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W:0]     prem_q, prem_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   quot_q, quot_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W:0]     shift_w;
  logic [DATA_W:0]     trial_w;
  logic                qbit_w;
  logic [DATA_W:0]     step_rem_w;
  logic [DATA_W-1:0]   step_quo_w;
  logic [DATA_W-1:0]   abs1_w;
  logic [DATA_W-1:0]   abs2_w;
  logic [DATA_W-1:0]   fin_q_w;
  logic [DATA_W-1:0]   fin_r_w;

  // One restoring shift-subtract step on the current partial remainder.
  always_comb begin
    shift_w    = {prem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    trial_w    = shift_w - {1'b0, dvs_q};
    qbit_w     = ~trial_w[DATA_W];
    step_rem_w = qbit_w ? trial_w : shift_w;
    step_quo_w = {dvd_q[DATA_W-2:0], qbit_w};
    abs1_w     = (div_signed && src1[DATA_W-1]) ? (~src1 + DATA_W'(1)) : src1;
    abs2_w     = (div_signed && src2[DATA_W-1]) ? (~src2 + DATA_W'(1)) : src2;
    fin_q_w    = dz_q   ? '1
               : qneg_q ? (~step_quo_w + DATA_W'(1)) : step_quo_w;
    fin_r_w    = rneg_q ? (~step_rem_w[DATA_W-1:0] + DATA_W'(1)) : step_rem_w[DATA_W-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (hi_wen) hi_d = hilo_wdata;
    if (lo_wen) lo_d = hilo_wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          dvd_d   = abs1_w;
          dvs_d   = abs2_w;
          prem_d  = '0;
          qneg_d  = div_signed & (src1[DATA_W-1] ^ src2[DATA_W-1]);
          rneg_d  = div_signed & src1[DATA_W-1];
          dz_d    = (src2 == '0);
        end
      end
      ST_BUSY: begin
        prem_d = step_rem_w;
        dvd_d  = step_quo_w;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          quot_d  = fin_q_w;
          rem_d   = fin_r_w;
        end
      end
      ST_DONE: begin
        // Division commit overrides a coincident MTHI/MTLO.
        if (ack) begin
          state_d = ST_IDLE;
          hi_d    = rem_q;
          lo_d    = quot_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush aborts everything: no HI/LO write, results keep their last values.
    if (cancel) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Bench for exe_div_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized divisions checked against an arithmetic reference.
module tb_exe_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, div_signed, ack, cancel, hi_wen, lo_wen;
  logic [31:0] src1, src2, hilo_wdata;
  logic        busy, done;
  logic [31:0] quot, rem, hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] mhi, mlo;

  exe_div_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .req(req), .div_signed(div_signed),
    .src1(src1), .src2(src2), .ack(ack), .cancel(cancel),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .hilo_wdata(hilo_wdata),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          hold;
    bit          mt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference quotient/remainder from plain arithmetic.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endtask

  // Issue req and wait for done; expects done on the 33rd edge after sampling.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit rnd);
    int n;
    div_signed = sgn; src1 = a; src2 = b; req = 1'b1;
    n = 0;
    do begin
      if (rnd && n > 0) begin
        src1 = $urandom; src2 = $urandom; div_signed = 1'($urandom_range(0, 1));
        hi_wen = 1'($urandom_range(0, 1)); lo_wen = 1'($urandom_range(0, 1));
        hilo_wdata = $urandom;
        if (hi_wen) mhi = hilo_wdata;
        if (lo_wen) mlo = hilo_wdata;
      end
      step();
      hi_wen = 1'b0; lo_wen = 1'b0;
      n++;
    end while (!done && n < 40);
    chk("latency", 32'(n), 32'd33);
  endtask

  task automatic commit(input logic [31:0] eq, input logic [31:0] er, input bit mt);
    ack = 1'b1;
    if (mt) begin
      hi_wen = 1'b1; lo_wen = 1'b1; hilo_wdata = 32'h5A5A_A5A5;
    end
    step();
    req = 1'b0; ack = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    mhi = er; mlo = eq;
    chk("hi_commit", hi, er);
    chk("lo_commit", lo, eq);
    chk("busy_after_ack", 32'(busy), 32'd0);
    chk("done_after_ack", 32'(done), 32'd0);
  endtask

  task automatic run_div(input vec_t v, input bit rnd);
    launch(v.sgn, v.a, v.b, rnd);
    chk("quot", quot, v.q);
    chk("rem", rem, v.r);
    for (int i = 0; i < v.hold; i++) begin
      step();
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_quot", quot, v.q);
      chk("hold_rem", rem, v.r);
      chk("hold_hi", hi, mhi);
      chk("hold_lo", lo, mlo);
    end
    commit(v.q, v.r, v.mt);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    logic [31:0] hs, ls, qs, rs;

    vecs[0] = '{1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          0, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0, 1'b0};
    vecs[3] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  0, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  0, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          0, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  0, 1'b0};
    vecs[8] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          5, 1'b0};
    vecs[9] = '{1'b0, 32'd1000,       32'd7,          32'd142,        32'd6,          0, 1'b1};

    resetn = 1'b0; req = 1'b0; div_signed = 1'b0; ack = 1'b0; cancel = 1'b0;
    hi_wen = 1'b0; lo_wen = 1'b0; src1 = '0; src2 = '0; hilo_wdata = '0;
    mhi = '0; mlo = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    resetn = 1'b1;
    step();

    // MTHI / MTLO while idle
    hi_wen = 1'b1; hilo_wdata = 32'hCAFE_0001; step(); hi_wen = 1'b0;
    chk("mthi", hi, 32'hCAFE_0001);
    lo_wen = 1'b1; hilo_wdata = 32'hCAFE_0002; step(); lo_wen = 1'b0;
    chk("mtlo", lo, 32'hCAFE_0002);
    mhi = 32'hCAFE_0001; mlo = 32'hCAFE_0002;

    for (int i = 0; i < 10; i++) run_div(vecs[i], 1'b0);

    // Cancel while cnt==10: back to idle, HI/LO untouched, then a fresh op
    hs = hi; ls = lo;
    div_signed = 1'b0; src1 = 32'd1000; src2 = 32'd3; req = 1'b1;
    for (int i = 0; i < 11; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0; req = 1'b0;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_hi", hi, hs);
    chk("cancel_lo", lo, ls);
    v = '{1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 1'b0};
    run_div(v, 1'b0);

    // Cancel while in DONE: no commit, results held
    hs = hi; ls = lo;
    launch(1'b1, 32'hFFFF_FC18, 32'd10, 1'b0);
    qs = quot; rs = rem;
    chk("pre_cancel_quot", qs, 32'hFFFF_FF9C);
    cancel = 1'b1; ack = 1'b1;
    step();
    cancel = 1'b0; ack = 1'b0; req = 1'b0;
    chk("dcancel_done", 32'(done), 32'd0);
    chk("dcancel_hi", hi, hs);
    chk("dcancel_lo", lo, ls);
    chk("dcancel_quot", quot, qs);
    chk("dcancel_rem", rem, rs);

    // Randomized divisions with MTHI/MTLO traffic while busy
    for (int i = 0; i < 25; i++) begin
      v.sgn = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      case ($urandom_range(0, 4))
        0:       v.b = 32'd0;
        1:       v.b = 32'($urandom_range(1, 15));
        2:       v.b = 32'hFFFF_FFFF;
        default: v.b = $urandom;
      endcase
      if (i == 0) begin v.sgn = 1'b1; v.a = 32'h8000_0000; v.b = 32'hFFFF_FFFF; end
      model(v.sgn, v.a, v.b, v.q, v.r);
      v.hold = $urandom_range(0, 3);
      v.mt   = 1'($urandom_range(0, 1));
      run_div(v, 1'b1);
    end

    // Asynchronous reset mid-operation
    div_signed = 1'b0; src1 = 32'd77; src2 = 32'd5; req = 1'b1;
    for (int i = 0; i < 10; i++) step();
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_quot", quot, 32'd0);
    chk("arst_rem", rem, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    req = 1'b0;
    step();
    resetn = 1'b1;
    mhi = '0; mlo = '0;
    step();
    v = '{1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1, 1'b1};
    run_div(v, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
